// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth digit decoder/accumulator:
// digit field positions, digit type and controller states.
package booth_pkg;

  localparam int unsigned DIG_W   = 3;
  localparam int unsigned DIG_NEG = 2;
  localparam int unsigned DIG_TWO = 1;
  localparam int unsigned DIG_ONE = 0;

  typedef logic [DIG_W-1:0] digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational partial-product generator: maps a multiplicand and one
// Booth radix-4 digit to a sign-extended 2N-bit partial product.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]   mcand,
  input  digit_t         digit,
  output logic [2*N-1:0] pp,
  output logic           illegal
);

  localparam int unsigned PW = 2 * N;

  logic [PW-1:0] mext;
  logic [PW-1:0] mag;

  assign mext = {{N{mcand[N-1]}}, mcand};

  // {one,two} both set has no meaning in radix-4 Booth; it contributes zero
  always_comb begin
    mag     = '0;
    illegal = digit[DIG_ONE] & digit[DIG_TWO];
    if (!illegal) begin
      if (digit[DIG_ONE]) begin
        mag = mext;
      end else if (digit[DIG_TWO]) begin
        mag = mext << 1;
      end
    end
  end

  // Invert-plus-one; a zero magnitude negates back to zero on its own
  assign pp = digit[DIG_NEG] ? (~mag + PW'(1)) : mag;

endmodule

// File: rtl/booth_r4_decode_acc.sv
// Sequential Booth radix-4 multiplier back end: accepts a multiplicand and a
// pre-encoded digit vector, accumulates one shifted partial product per cycle.
module booth_r4_decode_acc
  import booth_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0]              in_mcand,
  input  logic [DIG_W*(N/2)-1:0]    in_digits,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*N-1:0]            out_prod,
  output logic                      out_err
);

  localparam int unsigned ND = N / 2;
  localparam int unsigned PW = 2 * N;
  localparam int unsigned DW = DIG_W * ND;
  localparam int unsigned IW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(ND - 1);

  state_t        state;
  logic [N-1:0]  mcand_q;
  logic [DW-1:0] digits_q;
  logic [IW-1:0] idx;
  logic [PW-1:0] acc;
  logic [PW-1:0] pp;
  logic [PW-1:0] pp_sh;
  logic [PW-1:0] acc_nxt;
  logic          illegal;

  // The current digit always sits in the low field of the shifting digit register
  booth_pp_gen #(.N(N)) u_pp_gen (
    .mcand   (mcand_q),
    .digit   (digits_q[DIG_W-1:0]),
    .pp      (pp),
    .illegal (illegal)
  );

  assign pp_sh   = pp << {idx, 1'b0};
  assign acc_nxt = acc + pp_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mcand_q   <= '0;
      digits_q  <= '0;
      idx       <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= in_mcand;
            digits_q <= in_digits;
            acc      <= '0;
            idx      <= '0;
            out_err  <= 1'b0;
            in_ready <= 1'b0;
            state    <= ACC;
          end
        end
        ACC: begin
          acc      <= acc_nxt;
          digits_q <= digits_q >> DIG_W;
          idx      <= idx + IW'(1);
          if (illegal) begin
            out_err <= 1'b1;
          end
          if (idx == LAST_IDX) begin
            out_prod  <= acc_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_decode_acc.sv
// Bench for booth_r4_decode_acc (N=8): directed vector table, handshake and
// reset corner sequences, and random operations against an arithmetic model.
module tb_booth_r4_decode_acc;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 12;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_mcand = '0;
  logic [DW-1:0] in_digits = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_prod;
  logic          out_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_r4_decode_acc #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mcand  (in_mcand),
    .in_digits (in_digits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_err   (out_err)
  );

  typedef struct {
    string         name;
    logic [N-1:0]  m;
    logic [DW-1:0] digits;
    logic [PW-1:0] exp_prod;
    logic          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Product from the digit values themselves: M * sum(d_i * 4^i), illegal digits count as 0
  function automatic logic [PW-1:0] model(input logic [N-1:0] m, input logic [DW-1:0] d,
                                          output logic err);
    int s;
    s   = 0;
    err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] g;
      int v;
      g = d[3*i +: 3];
      v = 0;
      if (g[1] && g[0]) err = 1'b1;
      else if (g[0])    v = 1;
      else if (g[1])    v = 2;
      if (g[2]) v = -v;
      s += v * (1 << (2 * i));
    end
    return PW'(int'($signed(m)) * s);
  endfunction

  task automatic start_op(input logic [N-1:0] m, input logic [DW-1:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_start", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_mcand  = m;
    in_digits = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid; noise=1 drives junk handshakes meanwhile
  task automatic wait_valid(output int lat, input bit noise);
    lat = 0;
    while (lat < 20) begin
      if (noise) begin
        in_valid  = 1'($urandom);
        out_ready = 1'($urandom);
        in_mcand  = N'($urandom);
        in_digits = DW'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic finish_op(input logic [PW-1:0] exp_prod, input int hold);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check("prod_stable_wait", 64'(out_prod), 64'(exp_prod));
      check("valid_held_wait", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_drop_after_ready", 64'(out_valid), 64'd0);
    check("in_ready_after_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int            lat;
    int            seen;
    logic [PW-1:0] exp_p;
    logic          exp_e;

    vecs[0] = '{"m7_d0neg1_d1pos1", 8'd7,    12'h00D, 16'h0015, 1'b0};
    vecs[1] = '{"mneg128_d3neg2",   8'h80,   12'hC00, 16'h4000, 1'b0};
    vecs[2] = '{"m127_d3neg2",      8'h7F,   12'hC00, 16'hC080, 1'b0};
    vecs[3] = '{"m5_d1_illegal",    8'd5,    12'h018, 16'h0000, 1'b1};
    vecs[4] = '{"m5_clean_after",   8'd5,    12'h001, 16'h0005, 1'b0};
    vecs[5] = '{"mneg1_all_pos2",   8'hFF,   12'h492, 16'hFF56, 1'b0};
    vecs[6] = '{"m127_neg_zero",    8'h7F,   12'h004, 16'h0000, 1'b0};

    #12;
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_err",   64'(out_err),   64'd0);
    check("reset_out_prod",  64'(out_prod),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].m, vecs[i].digits);
      wait_valid(lat, 1'b0);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd4);
      check({vecs[i].name, "_prod"}, 64'(out_prod), 64'(vecs[i].exp_prod));
      check({vecs[i].name, "_err"}, 64'(out_err), 64'(vecs[i].exp_err));
      finish_op(vecs[i].exp_prod, 1);
    end

    // Consumer stalls for 10 cycles while the producer keeps offering new work
    start_op(8'd7, 12'h00D);
    wait_valid(lat, 1'b1);
    check("stall_latency", 64'(lat), 64'd4);
    check("stall_prod_initial", 64'(out_prod), 64'h0015);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_mcand  = N'($urandom);
      in_digits = DW'($urandom);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      check("stall_prod_stable", 64'(out_prod), 64'h0015);
      check("stall_in_ready_low", 64'(in_ready), 64'd0);
      check("stall_valid_high", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("stall_release_valid", 64'(out_valid), 64'd0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("stall_no_second_product", 64'(seen), 64'd0);
    check("stall_in_ready_back", 64'(in_ready), 64'd1);

    // Reset lands in the second ACC cycle, after an illegal digit 0 has set out_err
    start_op(8'h33, 12'h003);
    @(posedge clk);
    #2;
    check("pre_reset_err_set", 64'(out_err), 64'd1);
    rst = 1'b1;
    #1;
    check("midacc_reset_valid", 64'(out_valid), 64'd0);
    check("midacc_reset_err",   64'(out_err),   64'd0);
    check("midacc_reset_prod",  64'(out_prod),  64'd0);
    check("midacc_reset_ready", 64'(in_ready),  64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("post_reset_no_valid", 64'(seen), 64'd0);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);
    start_op(8'd7, 12'h00D);
    wait_valid(lat, 1'b0);
    check("post_reset_latency", 64'(lat), 64'd4);
    check("post_reset_prod", 64'(out_prod), 64'h0015);
    finish_op(16'h0015, 0);

    for (int i = 0; i < 40; i++) begin
      logic [N-1:0]  m;
      logic [DW-1:0] d;
      m     = N'($urandom);
      d     = DW'($urandom);
      exp_p = model(m, d, exp_e);
      start_op(m, d);
      wait_valid(lat, 1'((i % 2) == 1));
      check("rand_latency", 64'(lat), 64'd4);
      check("rand_prod", 64'(out_prod), 64'(exp_p));
      check("rand_err", 64'(out_err), 64'(exp_e));
      finish_op(exp_p, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
